// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for pipeline stages. Holds the occupancy
//                state encoding, slot-load selectors and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default widths shared by all pipeline stages
    localparam int unsigned c_inst_width      = 32;
    localparam int unsigned c_inst_addr_width = 9;
    localparam int unsigned c_thread_bits     = 2;
    localparam int unsigned c_stat_width      = 16;

    // Occupancy state encoding
    localparam logic [1:0] c_occ_empty = 2'd0;
    localparam logic [1:0] c_occ_one   = 2'd1;
    localparam logic [1:0] c_occ_full  = 2'd2;

    typedef enum logic [1:0] {
        OCC_EMPTY = c_occ_empty,
        OCC_ONE   = c_occ_one,
        OCC_FULL  = c_occ_full
    } occ_state_t;

    // Where a storage slot takes its next payload from
    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_SKID = 2'd1,
        SRC_IN   = 2'd2
    } slot_src_t;

    // Number of entries dropped in one cycle (0..3)
    function automatic logic [1:0] count_drops(input logic a, input logic b, input logic c);
        return 2'({1'b0, a}) + 2'({1'b0, b}) + 2'({1'b0, c});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sat_counter
//  Description : Up-counter that adds a multi-bit increment each cycle and
//                sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH     = c_stat_width,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     count
);

    localparam logic [WIDTH:0] c_max = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    // One extra bit so overflow is visible before clamping
    assign w_sum = {1'b0, r_count} + (WIDTH + 1)'(inc);

    // Accumulate, clamping at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_sum > c_max) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[WIDTH-1:0];
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : One-cycle pipeline register with a skid slot, registered
//                in_ready and per-thread flush with in-order compaction.
//                Optional statistics counters when PIPE_STAGE_STATS_EN is
//                defined (stall_count, flush_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int INST_WIDTH      = c_inst_width,
    parameter int INST_ADDR_WIDTH = c_inst_addr_width,
    parameter int THREAD_BITS     = c_thread_bits,
    parameter int STAT_WIDTH      = c_stat_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_WIDTH-1:0]      inst_in,
    input  logic [INST_ADDR_WIDTH-1:0] pc_in,
    input  logic [THREAD_BITS-1:0]     thread_id_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    output logic [THREAD_BITS-1:0]     thread_id_out,
    input  logic                       flush,
    input  logic [THREAD_BITS-1:0]     flush_tid
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]      stall_count,
    output logic [STAT_WIDTH-1:0]      flush_count
`endif
);

    occ_state_t                 r_state;
    occ_state_t                 w_state_nxt;
    logic                       r_in_ready;

    logic [INST_WIDTH-1:0]      r_main_inst;
    logic [INST_ADDR_WIDTH-1:0] r_main_pc;
    logic [THREAD_BITS-1:0]     r_main_tid;
    logic [INST_WIDTH-1:0]      r_skid_inst;
    logic [INST_ADDR_WIDTH-1:0] r_skid_pc;
    logic [THREAD_BITS-1:0]     r_skid_tid;

    logic      w_main_valid;
    logic      w_skid_valid;
    logic      w_accept;
    logic      w_transfer;
    logic      w_main_hit;
    logic      w_skid_hit;
    logic      w_in_hit;
    logic      w_keep_main;
    logic      w_keep_skid;
    logic      w_keep_in;
    slot_src_t w_main_src;
    slot_src_t w_skid_src;

    assign w_main_valid = (r_state != OCC_EMPTY);
    assign w_skid_valid = (r_state == OCC_FULL);

    assign w_accept   = in_valid & r_in_ready;
    assign w_transfer = w_main_valid & out_ready;

    assign w_main_hit = flush & (r_main_tid == flush_tid);
    assign w_skid_hit = flush & (r_skid_tid == flush_tid);
    assign w_in_hit   = flush & (thread_id_in == flush_tid);

    // A main entry leaving this cycle is delivered, so flush cannot touch it
    assign w_keep_main = w_main_valid & ~w_transfer & ~w_main_hit;
    assign w_keep_skid = w_skid_valid & ~w_skid_hit;
    assign w_keep_in   = w_accept & ~w_in_hit;

    // Compact survivors oldest-first (main, skid, incoming) into main then skid.
    // All three cannot survive together because a full stage never accepts.
    always_comb begin
        w_main_src  = SRC_HOLD;
        w_skid_src  = SRC_HOLD;
        w_state_nxt = OCC_EMPTY;
        if (w_keep_main) begin
            if (w_keep_skid) begin
                w_state_nxt = OCC_FULL;
            end else if (w_keep_in) begin
                w_skid_src  = SRC_IN;
                w_state_nxt = OCC_FULL;
            end else begin
                w_state_nxt = OCC_ONE;
            end
        end else if (w_keep_skid) begin
            w_main_src = SRC_SKID;
            if (w_keep_in) begin
                w_skid_src  = SRC_IN;
                w_state_nxt = OCC_FULL;
            end else begin
                w_state_nxt = OCC_ONE;
            end
        end else if (w_keep_in) begin
            w_main_src  = SRC_IN;
            w_state_nxt = OCC_ONE;
        end
    end

    // Occupancy state and registered ready (ready means skid slot is free)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != OCC_FULL);
        end
    end

    // Main payload: loaded only when a different entry moves in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_inst <= '0;
            r_main_pc   <= '0;
            r_main_tid  <= '0;
        end else if (w_main_src == SRC_SKID) begin
            r_main_inst <= r_skid_inst;
            r_main_pc   <= r_skid_pc;
            r_main_tid  <= r_skid_tid;
        end else if (w_main_src == SRC_IN) begin
            r_main_inst <= inst_in;
            r_main_pc   <= pc_in;
            r_main_tid  <= thread_id_in;
        end
    end

    // Skid payload: only ever filled from the input side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_skid_tid  <= '0;
        end else if (w_skid_src == SRC_IN) begin
            r_skid_inst <= inst_in;
            r_skid_pc   <= pc_in;
            r_skid_tid  <= thread_id_in;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = w_main_valid;
    assign inst_out      = r_main_inst;
    assign pc_out        = r_main_pc;
    assign thread_id_out = r_main_tid;

`ifdef PIPE_STAGE_STATS_EN
    logic       w_stall_inc;
    logic [1:0] w_drop_cnt;

    assign w_stall_inc = w_main_valid & ~out_ready;
    assign w_drop_cnt  = count_drops(w_main_valid & ~w_transfer & w_main_hit,
                                     w_skid_valid & w_skid_hit,
                                     w_accept & w_in_hit);

    pipe_sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .INC_WIDTH (1)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    pipe_sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .INC_WIDTH (2)
    ) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_drop_cnt),
        .count (flush_count)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid: vector table,
//                hand-written corner sequences and a queue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int c_sw = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic [8:0]  pc_in;
    logic [1:0]  thread_id_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [8:0]  pc_out;
    logic [1:0]  thread_id_out;
    logic        flush;
    logic [1:0]  flush_tid;
`ifdef PIPE_STAGE_STATS_EN
    logic [c_sw-1:0] stall_count;
    logic [c_sw-1:0] flush_count;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .INST_WIDTH      (32),
        .INST_ADDR_WIDTH (9),
        .THREAD_BITS     (2),
        .STAT_WIDTH      (c_sw)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inst_in       (inst_in),
        .pc_in         (pc_in),
        .thread_id_in  (thread_id_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .thread_id_out (thread_id_out),
        .flush         (flush),
        .flush_tid     (flush_tid)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_count   (stall_count),
        .flush_count   (flush_count)
`endif
    );

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [8:0]  pc;
        logic [1:0]  tid;
        logic        ordy;
        logic        fl;
        logic [1:0]  ftid;
        logic        exp_ov;
        logic [31:0] exp_inst;
        logic [8:0]  exp_pc;
        logic [1:0]  exp_tid;
        logic        exp_ir;
        int          exp_fc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [8:0]  pc;
        logic [1:0]  tid;
    } ent_t;

    vec_t vecs[13];
    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT state against the scoreboard queue
    task automatic sb_check();
        check("sb_out_valid", 64'(out_valid), 64'(sb.size() > 0));
        check("sb_in_ready", 64'(in_ready), 64'(sb.size() < 2));
        if (sb.size() > 0) begin
            check("sb_inst", 64'(inst_out), 64'(sb[0].inst));
            check("sb_pc", 64'(pc_out), 64'(sb[0].pc));
            check("sb_tid", 64'(thread_id_out), 64'(sb[0].tid));
        end
`ifdef PIPE_STAGE_STATS_EN
        check("sb_stall_count", 64'(stall_count), 64'(m_stall));
        check("sb_flush_count", 64'(flush_count), 64'(m_flush));
`endif
    endtask

    // Called at posedge+1: drive, check mid-cycle, update model, advance
    task automatic cycle(input logic iv, input logic [31:0] inst, input logic [8:0] pc,
                         input logic [1:0] tid, input logic ordy, input logic fl,
                         input logic [1:0] ftid);
        bit   acc;
        bit   xfer;
        ent_t e;
        in_valid     = iv;
        inst_in      = inst;
        pc_in        = pc;
        thread_id_in = tid;
        out_ready    = ordy;
        flush        = fl;
        flush_tid    = ftid;
        @(negedge clk);
        sb_check();
        acc  = iv && (sb.size() < 2);
        xfer = (sb.size() > 0) && ordy;
        if ((sb.size() > 0) && !ordy && (m_stall < 15)) m_stall++;
        if (xfer) void'(sb.pop_front());
        if (fl) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].tid == ftid) begin
                    sb.delete(i);
                    m_flush++;
                end
            end
        end
        if (acc) begin
            if (fl && (tid == ftid)) begin
                m_flush++;
            end else begin
                e.inst = inst;
                e.pc   = pc;
                e.tid  = tid;
                sb.push_back(e);
            end
        end
        if (m_flush > 15) m_flush = 15;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv  inst          pc     tid   or    fl    ftid  ov    inst          pc     tid   ir    fc
        vecs[0]  = '{1'b1, 32'h11111111, 9'd5,  2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h11111111, 9'd5,  2'd1, 1'b1, 0};
        vecs[1]  = '{1'b1, 32'hAAAA0001, 9'd10, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hAAAA0001, 9'd10, 2'd0, 1'b1, 0};
        vecs[2]  = '{1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 0};
        vecs[3]  = '{1'b1, 32'hBBBB0002, 9'd20, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, 32'hBBBB0002, 9'd20, 2'd2, 1'b1, 0};
        vecs[4]  = '{1'b1, 32'hCCCC0003, 9'd30, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1, 32'hBBBB0002, 9'd20, 2'd2, 1'b0, 0};
        vecs[5]  = '{1'b1, 32'hDDDD0004, 9'd40, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 32'hBBBB0002, 9'd20, 2'd2, 1'b0, 0};
        vecs[6]  = '{1'b0, 32'h0,        9'd0,  2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 32'hCCCC0003, 9'd30, 2'd3, 1'b1, 1};
        vecs[7]  = '{1'b1, 32'hEEEE0005, 9'd50, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 3};
        vecs[8]  = '{1'b1, 32'hFFFF0006, 9'd60, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFF0006, 9'd60, 2'd0, 1'b1, 3};
        vecs[9]  = '{1'b1, 32'h12340007, 9'd70, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h12340007, 9'd70, 2'd1, 1'b1, 3};
        vecs[10] = '{1'b1, 32'h56780008, 9'd80, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h12340007, 9'd70, 2'd1, 1'b0, 3};
        vecs[11] = '{1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 4};
        vecs[12] = '{1'b1, 32'h9ABC0009, 9'd90, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        9'd0,  2'd0, 1'b1, 5};

        reset        = 1'b1;
        in_valid     = 1'b0;
        inst_in      = '0;
        pc_in        = '0;
        thread_id_in = '0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        flush_tid    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_inst", 64'(inst_out), 64'd0);
        check("reset_pc", 64'(pc_out), 64'd0);
        check("reset_tid", 64'(thread_id_out), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_STATS_EN
        check("reset_stall_count", 64'(stall_count), 64'd0);
        check("reset_flush_count", 64'(flush_count), 64'd0);
`endif
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].tid,
                  vecs[i].ordy, vecs[i].fl, vecs[i].ftid);
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d_inst", i), 64'(inst_out), 64'(vecs[i].exp_inst));
                check($sformatf("vec%0d_pc", i), 64'(pc_out), 64'(vecs[i].exp_pc));
                check($sformatf("vec%0d_tid", i), 64'(thread_id_out), 64'(vecs[i].exp_tid));
            end
`ifdef PIPE_STAGE_STATS_EN
            check($sformatf("vec%0d_flush_count", i), 64'(flush_count), 64'(vecs[i].exp_fc));
`endif
        end

        // Back-pressure: A then B offered while blocked, then drained in order
        cycle(1'b1, 32'hA0A0A0A0, 9'd100, 2'd1, 1'b0, 1'b0, 2'd0);
        cycle(1'b1, 32'hB0B0B0B0, 9'd101, 2'd2, 1'b0, 1'b0, 2'd0);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(inst_out), 64'hA0A0A0A0);
        cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b1, 1'b0, 2'd0);
        check("bp_b_valid", 64'(out_valid), 64'd1);
        check("bp_b_inst", 64'(inst_out), 64'hB0B0B0B0);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b1, 1'b0, 2'd0);
        check("bp_drained", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
        // Stall counter saturation
        cycle(1'b1, 32'h5A5A5A5A, 9'd7, 2'd0, 1'b0, 1'b0, 2'd0);
        repeat (20) cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        check("stall_saturate", 64'(stall_count), 64'd15);
`endif

        // Drain, fill to FULL, then reset mid-cycle
        repeat (2) cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b1, 1'b0, 2'd0);
        cycle(1'b1, 32'hC1C1C1C1, 9'd200, 2'd0, 1'b0, 1'b0, 2'd0);
        cycle(1'b1, 32'hC2C2C2C2, 9'd201, 2'd1, 1'b0, 1'b0, 2'd0);
        check("full_before_reset", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_inst", 64'(inst_out), 64'd0);
        check("async_reset_pc", 64'(pc_out), 64'd0);
        check("async_reset_tid", 64'(thread_id_out), 64'd0);
        check("async_reset_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b1, 1'b0, 2'd0);

        // Random traffic against the scoreboard
        for (int n = 0; n < 200; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 9'($urandom), 2'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
                  2'($urandom));
        end
        repeat (3) cycle(1'b0, 32'h0, 9'd0, 2'd0, 1'b1, 1'b0, 2'd0);
        check("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INST_WIDTH, 32, instruction payload width.
- INST_ADDR_WIDTH, 9, PC width.
- THREAD_BITS, 2, thread-id width.
- STAT_WIDTH, 16, statistics counter width; used only with PIPE_STAGE_STATS_EN.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry; registered.
- inst_in  in  INST_WIDTH  instruction.
- pc_in  in  INST_ADDR_WIDTH  PC of instruction.
- thread_id_in  in  THREAD_BITS  owning thread.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- inst_out, pc_out, thread_id_out  out  as inputs  main entry payload.
- flush  in  1  invalidate entries of one thread.
- flush_tid  in  THREAD_BITS  thread to flush.
- stall_count, flush_count  out  STAT_WIDTH each  present only with PIPE_STAGE_STATS_EN.

Function
REQ-003 Storage SHALL be a main register driving the outputs plus one skid register; occupancy states EMPTY, ONE (main only), FULL (main and skid).
REQ-004 Accept SHALL occur when in_valid and in_ready are both high; transfer SHALL occur when out_valid and out_ready are both high.
REQ-005 in_ready SHALL equal NOT skid-valid, registered; no combinational path from out_ready to in_ready.
REQ-006 Latency SHALL be one cycle: an entry accepted into EMPTY appears on the outputs the next cycle.
REQ-007 Transitions without flush SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept, no transfer -> FULL (entry into skid).
- ONE + accept + transfer -> ONE (new entry into main).
- ONE + transfer -> EMPTY.
- FULL + transfer -> ONE (skid moves to main).
- FULL never accepts.
REQ-008 With flush high, main, skid and any same-cycle accepted entry whose thread id equals flush_tid SHALL be dropped.
REQ-009 After a flush the survivors SHALL be compacted in order: main, then skid, then incoming. Oldest surviving entry goes to main; a second survivor goes to skid.
REQ-010 An entry transferred in the flush cycle SHALL count as delivered; flush SHALL NOT suppress that cycle's out_valid.
REQ-011 Order of entries from any one thread SHALL be preserved; no entry SHALL be duplicated or lost except by flush.
REQ-012 Payload registers SHALL hold their value when not loaded; payload of an invalid slot is don't-care.

Reset
REQ-013 On reset all registers SHALL clear asynchronously. State is EMPTY; out_valid=0, inst_out=0, pc_out=0, thread_id_out=0, in_ready=1, counters=0.
REQ-014 Reset asserted mid-operation SHALL discard all held entries without emitting them.

Configuration
REQ-015 With PIPE_STAGE_STATS_EN defined, the following SHALL be present:
- stall_count: increments each cycle with out_valid=1 and out_ready=0.
- flush_count: increments by the number of entries dropped (0-3) per cycle.
- Both saturate at all-ones.
REQ-016 Without PIPE_STAGE_STATS_EN, the counters, their ports and their logic SHALL be absent; remaining behaviour is identical.

Structure
REQ-017 Package pipe_pkg SHALL hold the occupancy state encoding (EMPTY=0, ONE=1, FULL=2) and default width constants shared with other pipeline stages.
REQ-018 The saturating counter SHALL be a sub-module pipe_sat_counter (parameters WIDTH, increment width), instantiated twice under PIPE_STAGE_STATS_EN.

Verification
REQ-019 Accept 0x11111111 pc=5 tid=1 with out_ready=1 -> next cycle out_valid=1, inst_out=0x11111111, pc_out=5, thread_id_out=1.
REQ-020 out_ready=0, offer A then B -> A held on outputs, in_ready=0 after B; raise out_ready -> A then B delivered on consecutive cycles, in_ready returns to 1.
REQ-021 FULL with main tid=2, skid tid=3; flush tid=2 -> next cycle main holds the tid=3 entry, state ONE, in_ready=1; flush_count=1 if stats enabled.
REQ-022 ONE with main tid=0, incoming tid=0 accepted, flush tid=0 -> both dropped, out_valid=0; flush_count=2.
REQ-023 Assert reset while FULL -> outputs zero, in_ready=1 immediately, without waiting for a clock edge; no entry emitted after release.
REQ-024 Stats build, STAT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count saturates at 15.
